// File: rtl/regfile_dump_reader.sv
// Streams register-file contents (full dump or single peek) over a valid/ready port.
// Optional XOR checksum trailer word when REGDUMP_CHECKSUM_EN is defined.
module regfile_dump_reader #(
  parameter int unsigned REGSIZE = 5,
  parameter int unsigned DIGIT   = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               single,
  input  logic [REGSIZE-1:0] peek_addr,
  output logic [REGSIZE-1:0] read_address,
  input  logic [DIGIT-1:0]   read_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DIGIT-1:0]   out_data,
  output logic [REGSIZE-1:0] out_index,
  output logic               out_last,
  output logic               busy,
  output logic               done
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] SEND  = 3'd2;
`ifdef REGDUMP_CHECKSUM_EN
  localparam logic [2:0] CKSUM = 3'd3;
`endif
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [REGSIZE-1:0] index_q, index_d;
  logic [REGSIZE-1:0] last_index_q, last_index_d;
  logic               out_valid_q, out_valid_d;
  logic [DIGIT-1:0]   out_data_q, out_data_d;
  logic [REGSIZE-1:0] out_index_q, out_index_d;
  logic               out_last_q, out_last_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
`ifdef REGDUMP_CHECKSUM_EN
  logic [DIGIT-1:0]   cksum_q, cksum_d;
`endif

  // Next-state and output computation
  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    last_index_d = last_index_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_index_d  = out_index_q;
    out_last_d   = out_last_q;
`ifdef REGDUMP_CHECKSUM_EN
    cksum_d      = cksum_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          index_d      = single ? peek_addr : '0;
          last_index_d = single ? peek_addr : '1;
          out_last_d   = 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
          cksum_d      = '0;
`endif
          state_d      = FETCH;
        end
      end
      FETCH: begin
        out_data_d  = read_data;
        out_index_d = index_q;
        out_valid_d = 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
        out_last_d  = 1'b0;
`else
        out_last_d  = (index_q == last_index_q);
`endif
        state_d     = SEND;
      end
      SEND: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
          cksum_d     = cksum_q ^ out_data_q;
`endif
          // Compare before increment so a full dump never wraps the index
          if (index_q == last_index_q) begin
`ifdef REGDUMP_CHECKSUM_EN
            state_d = CKSUM;
`else
            state_d = DONE;
`endif
          end else begin
            index_d = REGSIZE'(index_q + 1'b1);
            state_d = FETCH;
          end
        end
      end
`ifdef REGDUMP_CHECKSUM_EN
      CKSUM: begin
        if (!out_valid_q) begin
          out_data_d  = cksum_q;
          out_index_d = '0;
          out_last_d  = 1'b1;
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = DONE;
        end
      end
`endif
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      index_q      <= '0;
      last_index_q <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_index_q  <= '0;
      out_last_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
      cksum_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      last_index_q <= last_index_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_index_q  <= out_index_d;
      out_last_q   <= out_last_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef REGDUMP_CHECKSUM_EN
      cksum_q      <= cksum_d;
`endif
    end
  end

  // The walking index is itself the registered read address
  assign read_address = index_q;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_index    = out_index_q;
  assign out_last     = out_last_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: table-driven operations, hand-written corner
// sequences and randomized runs against a queue-based stream model.
module tb_regfile_dump_reader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        single = 1'b0;
  logic [4:0]  peek_addr = '0;
  logic [4:0]  read_address;
  logic [31:0] read_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [4:0]  out_index;
  logic        out_last;
  logic        busy;
  logic        done;

  logic [31:0] rf [32];

  regfile_dump_reader #(.REGSIZE(5), .DIGIT(32)) dut (
    .clock(clock), .reset(reset), .start(start), .single(single),
    .peek_addr(peek_addr), .read_address(read_address), .read_data(read_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;
  assign read_data = rf[read_address];

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  idx;
    logic        last;
  } word_t;

`ifdef REGDUMP_CHECKSUM_EN
  localparam bit CK = 1'b1;
  localparam int DUMP_WORDS = 33;
  localparam int PEEK_WORDS = 2;
  localparam logic [31:0] DUMP_FINAL = 32'h0000_0100;
`else
  localparam bit CK = 1'b0;
  localparam int DUMP_WORDS = 32;
  localparam int PEEK_WORDS = 1;
  localparam logic [31:0] DUMP_FINAL = 32'h0000_011F;
`endif

  int n_pass = 0;
  int n_total = 0;
  word_t got_q[$];
  word_t exp_q[$];
  int done_cnt = 0;
  int hold_err = 0;
  bit mon_en = 1'b0;
  bit prev_stall = 1'b0;
  word_t prev_w;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Stream monitor: collects accepted words, done pulses and stall stability
  always @(negedge clock) begin
    if (mon_en) begin
      if (prev_stall && (!out_valid || {out_data, out_index, out_last} != prev_w)) hold_err++;
      if (out_valid && out_ready) got_q.push_back('{out_data, out_index, out_last});
      if (done) done_cnt++;
      prev_stall = out_valid && !out_ready;
      prev_w = '{out_data, out_index, out_last};
    end
  end

  task automatic std_rf();
    rf[0] = 32'h0;
    for (int i = 1; i < 32; i++) rf[i] = 32'h100 + 32'(i);
  endtask

  // Reference: list of registers to visit, then optional XOR trailer
  task automatic build_model(input logic s, input logic [4:0] p);
    logic [31:0] x;
    int lo, hi;
    exp_q.delete();
    x = 32'h0;
    lo = s ? int'(p) : 0;
    hi = s ? int'(p) : 31;
    for (int i = lo; i <= hi; i++) begin
      exp_q.push_back('{rf[i], 5'(i), (!CK && i == hi)});
      x ^= rf[i];
    end
    if (CK) exp_q.push_back('{x, 5'd0, 1'b1});
  endtask

  task automatic drain(input string name);
    int cyc;
    cyc = 0;
    out_ready = 1'b1;
    while (busy && cyc < 500) begin
      @(posedge clock); #1;
      cyc++;
    end
    check({name, "_drain_timeout"}, 64'(busy), 64'd0);
  endtask

  task automatic run_op(input logic s, input logic [4:0] p, input bit rnd);
    int cyc;
    build_model(s, p);
    got_q.delete();
    done_cnt = 0;
    hold_err = 0;
    prev_stall = 1'b0;
    @(posedge clock); #1;
    start = 1'b1; single = s; peek_addr = p;
    out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    mon_en = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    single = 1'($urandom);
    peek_addr = 5'($urandom);
    cyc = 0;
    while (busy && cyc < 1500) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      @(posedge clock); #1;
      cyc++;
    end
    @(negedge clock);
    mon_en = 1'b0;
    check("op_timeout", 64'(busy), 64'd0);
    check("op_words", 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("op_word%0d", i), 64'(got_q[i]), 64'(exp_q[i]));
    check("op_done_pulses", 64'(done_cnt), 64'd1);
    check("op_hold_stable", 64'(hold_err), 64'd0);
  endtask

  typedef struct {
    logic        single;
    logic [4:0]  peek;
    bit          rnd;
    int          exp_words;
    logic [31:0] exp_first;
    logic [31:0] exp_final;
  } vec_t;

  vec_t vecs [5];
  bit   ok;

  initial begin
    std_rf();
    vecs[0] = '{1'b0, 5'd0,  1'b0, DUMP_WORDS, 32'h0,   DUMP_FINAL};
    vecs[1] = '{1'b1, 5'd7,  1'b0, PEEK_WORDS, 32'h107, 32'h107};
    vecs[2] = '{1'b1, 5'd0,  1'b0, PEEK_WORDS, 32'h0,   32'h0};
    vecs[3] = '{1'b1, 5'd31, 1'b1, PEEK_WORDS, 32'h11F, 32'h11F};
    vecs[4] = '{1'b0, 5'd9,  1'b1, DUMP_WORDS, 32'h0,   DUMP_FINAL};

    // Reset state
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_read_address", 64'(read_address), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);

    // Table-driven operations
    for (int v = 0; v < 5; v++) begin
      run_op(vecs[v].single, vecs[v].peek, vecs[v].rnd);
      check($sformatf("vec%0d_words", v), 64'(got_q.size()), 64'(vecs[v].exp_words));
      if (got_q.size() > 0) begin
        check($sformatf("vec%0d_first", v), 64'(got_q[0].data), 64'(vecs[v].exp_first));
        check($sformatf("vec%0d_final", v), 64'(got_q[got_q.size()-1].data), 64'(vecs[v].exp_final));
        check($sformatf("vec%0d_final_last", v), 64'(got_q[got_q.size()-1].last), 64'd1);
      end
      check($sformatf("vec%0d_idle", v), 64'(busy), 64'd0);
    end
    if (CK && got_q.size() == 33)
      check("cksum_word31_last", 64'(got_q[31].last), 64'd0);

    // Latency: FETCH cycle then valid; valid drops after handshake
    @(posedge clock); #1;
    start = 1'b1; single = 1'b1; peek_addr = 5'd7; out_ready = 1'b0;
    @(posedge clock); #1;
    start = 1'b0;
    check("lat_fetch_busy", 64'(busy), 64'd1);
    check("lat_fetch_valid", 64'(out_valid), 64'd0);
    check("lat_read_address", 64'(read_address), 64'd7);
    @(posedge clock); #1;
    check("lat_valid", 64'(out_valid), 64'd1);
    check("lat_word", 64'({out_data, out_index, out_last}), 64'({32'h107, 5'd7, !CK}));
    out_ready = 1'b1;
    @(posedge clock); #1;
    check("lat_valid_drop", 64'(out_valid), 64'd0);
    drain("lat");

    // Backpressure held at index 3
    @(posedge clock); #1;
    start = 1'b1; single = 1'b0; out_ready = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin
      if (out_valid && out_index == 5'd3) ok = 1'b1;
      else begin @(posedge clock); #1; end
    end
    out_ready = 1'b0;
    check("bp_reach3", 64'(ok), 64'd1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clock); #1;
      check($sformatf("bp_hold%0d", c), 64'({out_valid, out_data, out_index}), 64'({1'b1, 32'h103, 5'd3}));
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    @(posedge clock); #1;
    check("bp_next", 64'({out_valid, out_data, out_index}), 64'({1'b1, 32'h104, 5'd4}));
    drain("bp");

    // Start while busy ignored; reset at index 10 aborts
    @(posedge clock); #1;
    start = 1'b1; single = 1'b0; out_ready = 1'b1;
    @(posedge clock); #1;
    single = 1'b1; peek_addr = 5'd20;
    repeat (3) begin @(posedge clock); #1; end
    start = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin
      if (out_valid && out_index == 5'd10) ok = 1'b1;
      else begin @(posedge clock); #1; end
    end
    check("busy_start_ignored", 64'({ok, out_data}), 64'({1'b1, 32'h10A}));
    reset = 1'b1;
    #1;
    check("abort_valid", 64'(out_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    start = 1'b1; single = 1'b0; out_ready = 1'b0;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
    check("restart_word", 64'({out_valid, out_data, out_index}), 64'({1'b1, 32'h0, 5'd0}));
    drain("restart");

    // Randomized register contents, modes and backpressure
    for (int t = 0; t < 15; t++) begin
      rf[0] = 32'h0;
      for (int i = 1; i < 32; i++) rf[i] = $urandom;
      run_op(1'($urandom_range(0, 1)), 5'($urandom), 1'b1);
    end
    std_rf();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
